// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INST = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    localparam int DEF_TIMEOUT = 255;

    // Count value seen in the last allowed no-ack cycle; the abort fires there.
    function automatic logic [7:0] wdog_tc(input int timeout);
        return 8'(timeout - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_wdog.sv
// Clearable 8-bit saturating watchdog; expired flags the TIMEOUT-th no-ack cycle.
module arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = inc && (count == wdog_tc(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus between instruction fetch and data access; data has priority.
// state   | meaning
// IDLE    | no transaction; arbitrate, data wins
// INST    | fetch owns the bus, waiting for mem_ack
// DATA    | load/store owns the bus, waiting for mem_ack
// DONE    | ready (and bus_err on abort) pulses for the granted port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_ready,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ready,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_inst,
    output logic              stall_data,
    output logic              bus_err
);

    arb_state_t        state;
    logic              busy;
    logic              grant;
    logic              gnt;
    logic              wd_expired;
    logic [DATA_W-1:0] done_rdata;

    assign busy  = (state == ST_INST) || (state == ST_DATA);
    assign grant = (state == ST_IDLE) && (data_req || inst_req);
    assign gnt   = (state == ST_DATA) ? GNT_DATA : GNT_INST;

    // Stores and aborted transactions return zero.
    assign done_rdata = (mem_ack && !mem_wr) ? mem_rdata : '0;

    arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant),
        .inc     (busy && !mem_ack),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= 4'b0000;
            inst_rdata <= '0;
            data_rdata <= '0;
            inst_ready <= 1'b0;
            data_ready <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            inst_ready <= 1'b0;
            data_ready <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (data_req) begin
                        state     <= ST_DATA;
                        mem_req   <= 1'b1;
                        mem_wr    <= data_wr;
                        mem_addr  <= data_addr;
                        mem_wdata <= data_wdata;
                        mem_wstrb <= data_wr ? data_wstrb : 4'b0000;
                    end else if (inst_req) begin
                        state     <= ST_INST;
                        mem_req   <= 1'b1;
                        mem_wr    <= 1'b0;
                        mem_addr  <= inst_addr;
                        mem_wdata <= '0;
                        mem_wstrb <= 4'b0000;
                    end
                end
                ST_INST, ST_DATA: begin
                    if (mem_ack || wd_expired) begin
                        state   <= ST_DONE;
                        mem_req <= 1'b0;
                        bus_err <= !mem_ack;
                        if (gnt == GNT_DATA) begin
                            data_rdata <= done_rdata;
                            data_ready <= 1'b1;
                        end else begin
                            inst_rdata <= done_rdata;
                            inst_ready <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall_inst = inst_req & ~inst_ready;
    assign stall_data = data_req & ~data_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_inst;
    logic        stall_data;
    logic        bus_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [31:0] exp_inst_rd;
    logic [31:0] exp_data_rd;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_ready (inst_ready),
        .data_req   (data_req),
        .data_wr    (data_wr),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_wstrb (data_wstrb),
        .data_rdata (data_rdata),
        .data_ready (data_ready),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .stall_inst (stall_inst),
        .stall_data (stall_data),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from IDLE: ack arrives after `delay` no-ack bus cycles.
    task automatic do_txn(input bit is_data, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws, input int delay,
                          input logic [31:0] rd, input string tag);
        bit          eff_wr;
        logic [31:0] exp_rd;
        logic [3:0]  exp_ws;
        eff_wr = is_data & wr;
        exp_rd = eff_wr ? 32'h0 : rd;
        exp_ws = eff_wr ? ws : 4'b0000;
        if (is_data) begin
            data_req = 1'b1; data_wr = wr; data_addr = addr; data_wdata = wd; data_wstrb = ws;
        end else begin
            inst_req = 1'b1; inst_addr = addr;
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== addr) begin
            errors++;
            $display("FAIL %s grant_bus: req=%b addr=%h want req=1 addr=%h", tag, mem_req, mem_addr, addr);
        end
        checks++;
        if (mem_wr !== eff_wr || mem_wstrb !== exp_ws || (eff_wr && mem_wdata !== wd)) begin
            errors++;
            $display("FAIL %s grant_wr: wr=%b wstrb=%b wdata=%h want wr=%b wstrb=%b wdata=%h",
                     tag, mem_wr, mem_wstrb, mem_wdata, eff_wr, exp_ws, wd);
        end
        data_addr = $urandom; inst_addr = $urandom; data_wdata = $urandom;
        data_wstrb = 4'($urandom); data_wr = 1'($urandom);
        for (int i = 0; i < delay; i++) begin
            tick();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== addr || inst_ready !== 1'b0 || data_ready !== 1'b0
                || (is_data ? stall_data : stall_inst) !== 1'b1) begin
                errors++;
                $display("FAIL %s wait_hold: req=%b addr=%h rdy=%b%b want req=1 addr=%h rdy=00 stall=1",
                         tag, mem_req, mem_addr, inst_ready, data_ready, addr);
            end
        end
        mem_ack = 1'b1; mem_rdata = rd;
        tick();
        mem_ack = 1'b0; mem_rdata = $urandom;
        checks++;
        if ((is_data ? data_ready : inst_ready) !== 1'b1 || (is_data ? inst_ready : data_ready) !== 1'b0) begin
            errors++;
            $display("FAIL %s ready: inst_ready=%b data_ready=%b want port=%0d only", tag, inst_ready, data_ready, is_data);
        end
        checks++;
        if ((is_data ? data_rdata : inst_rdata) !== exp_rd) begin
            errors++;
            $display("FAIL %s rdata: got %h want %h", tag, is_data ? data_rdata : inst_rdata, exp_rd);
        end
        checks++;
        if ((is_data ? inst_rdata : data_rdata) !== (is_data ? exp_inst_rd : exp_data_rd)) begin
            errors++;
            $display("FAIL %s other_rdata_hold: got %h want %h", tag, is_data ? inst_rdata : data_rdata,
                     is_data ? exp_inst_rd : exp_data_rd);
        end
        checks++;
        if (mem_req !== 1'b0 || bus_err !== 1'b0 || (is_data ? stall_data : stall_inst) !== 1'b0) begin
            errors++;
            $display("FAIL %s done_ctrl: req=%b err=%b stall=%b want 0 0 0", tag, mem_req, bus_err,
                     is_data ? stall_data : stall_inst);
        end
        if (is_data) exp_data_rd = exp_rd; else exp_inst_rd = exp_rd;
        if (is_data) data_req = 1'b0; else inst_req = 1'b0;
        tick();
        checks++;
        if (inst_ready !== 1'b0 || data_ready !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: rdy=%b%b req=%b want 000", tag, inst_ready, data_ready, mem_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0;
        data_addr = '0; data_wdata = '0; data_wstrb = '0; mem_rdata = '0; mem_ack = 1'b0;
        exp_inst_rd = '0; exp_data_rd = '0;
        #22;
        checks++;
        if ({mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_bus: req=%b wr=%b addr=%h wdata=%h wstrb=%b want all 0",
                     mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb);
        end
        checks++;
        if ({inst_rdata, data_rdata, inst_ready, data_ready, bus_err, stall_inst, stall_data} !== '0) begin
            errors++;
            $display("FAIL reset_ports: irdata=%h drdata=%h rdy=%b%b err=%b stall=%b%b want all 0",
                     inst_rdata, data_rdata, inst_ready, data_ready, bus_err, stall_inst, stall_data);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        do_txn(1'b0, 1'b0, 32'hBFC00000, 32'h0, 4'h0, 2, 32'h3C08BFAF, "fetch");
    endtask

    task automatic test_store();
        do_txn(1'b1, 1'b1, 32'h00000020, 32'hDEADBEEF, 4'b0011, 1, 32'h12345678, "store");
    endtask

    task automatic test_ack_idle();
        mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
        tick();
        tick();
        mem_ack = 1'b0;
        checks++;
        if (inst_ready !== 1'b0 || data_ready !== 1'b0 || mem_req !== 1'b0
            || inst_rdata !== exp_inst_rd || data_rdata !== exp_data_rd) begin
            errors++;
            $display("FAIL ack_idle: rdy=%b%b req=%b irdata=%h drdata=%h want 00 0 %h %h",
                     inst_ready, data_ready, mem_req, inst_rdata, data_rdata, exp_inst_rd, exp_data_rd);
        end
    endtask

    task automatic test_collision();
        logic [31:0] faddr;
        logic [31:0] r1;
        logic [31:0] r2;
        faddr = $urandom; r1 = $urandom; r2 = $urandom;
        inst_req = 1'b1; inst_addr = faddr;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h00000010;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_wr !== 1'b0 || stall_inst !== 1'b1) begin
            errors++;
            $display("FAIL coll_first: req=%b addr=%h wr=%b stall_inst=%b want 1 00000010 0 1",
                     mem_req, mem_addr, mem_wr, stall_inst);
        end
        mem_ack = 1'b1; mem_rdata = r1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (data_ready !== 1'b1 || data_rdata !== r1 || inst_ready !== 1'b0 || stall_inst !== 1'b1) begin
            errors++;
            $display("FAIL coll_data_done: drdy=%b drdata=%h irdy=%b stall_inst=%b want 1 %h 0 1",
                     data_ready, data_rdata, inst_ready, stall_inst, r1);
        end
        exp_data_rd = r1;
        data_req = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b0 || stall_inst !== 1'b1) begin
            errors++;
            $display("FAIL coll_idle: req=%b stall_inst=%b want 0 1", mem_req, stall_inst);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== faddr || stall_inst !== 1'b1) begin
            errors++;
            $display("FAIL coll_second: req=%b addr=%h stall_inst=%b want 1 %h 1", mem_req, mem_addr, stall_inst, faddr);
        end
        mem_ack = 1'b1; mem_rdata = r2;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (inst_ready !== 1'b1 || inst_rdata !== r2 || stall_inst !== 1'b0 || data_rdata !== r1) begin
            errors++;
            $display("FAIL coll_inst_done: irdy=%b irdata=%h stall=%b drdata=%h want 1 %h 0 %h",
                     inst_ready, inst_rdata, stall_inst, data_rdata, r2, r1);
        end
        exp_inst_rd = r2;
        inst_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout(input bit ack_last);
        logic [31:0] r;
        r = $urandom;
        data_req = 1'b1; data_wr = 1'b0; data_addr = $urandom;
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL to_start: req=%b want 1", mem_req);
        end
        for (int i = 1; i < TO; i++) begin
            tick();
            checks++;
            if (mem_req !== 1'b1 || bus_err !== 1'b0 || data_ready !== 1'b0) begin
                errors++;
                $display("FAIL to_wait%0d: req=%b err=%b rdy=%b want 1 0 0", i, mem_req, bus_err, data_ready);
            end
        end
        if (ack_last) begin
            mem_ack = 1'b1; mem_rdata = r;
        end
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || data_ready !== 1'b1 || bus_err !== !ack_last
            || data_rdata !== (ack_last ? r : 32'h0)) begin
            errors++;
            $display("FAIL to_end(ack=%0d): req=%b rdy=%b err=%b rdata=%h want 0 1 %b %h", ack_last,
                     mem_req, data_ready, bus_err, data_rdata, !ack_last, ack_last ? r : 32'h0);
        end
        exp_data_rd = ack_last ? r : 32'h0;
        data_req = 1'b0;
        tick();
        checks++;
        if (bus_err !== 1'b0 || data_ready !== 1'b0) begin
            errors++;
            $display("FAIL to_after: err=%b rdy=%b want 0 0", bus_err, data_ready);
        end
    endtask

    task automatic test_async_reset();
        inst_req = 1'b1; inst_addr = 32'h00400000;
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre: req=%b want 1", mem_req);
        end
        #2;
        rst = 1'b1; inst_req = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || inst_ready !== 1'b0 || stall_inst !== 1'b0 || inst_rdata !== 32'h0) begin
            errors++;
            $display("FAIL ar_now: req=%b addr=%h rdy=%b stall=%b rdata=%h want 0 0 0 0 0",
                     mem_req, mem_addr, inst_ready, stall_inst, inst_rdata);
        end
        exp_inst_rd = '0; exp_data_rd = '0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        do_txn(1'b0, 1'b0, 32'h00400004, 32'h0, 4'h0, 0, 32'h8FBF0010, "post_reset");
    endtask

    task automatic test_back_to_back();
        int c1;
        int c2;
        logic [31:0] r1;
        logic [31:0] r2;
        r1 = $urandom; r2 = $urandom;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h00001000;
        tick();
        mem_ack = 1'b1; mem_rdata = r1;
        tick();
        mem_ack = 1'b0;
        c1 = cyc;
        checks++;
        if (data_ready !== 1'b1 || data_rdata !== r1) begin
            errors++;
            $display("FAIL b2b_first: rdy=%b rdata=%h want 1 %h", data_ready, data_rdata, r1);
        end
        data_addr = 32'h00001004;
        tick();
        checks++;
        if (data_ready !== 1'b0 || mem_req !== 1'b0 || stall_data !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: rdy=%b req=%b stall=%b want 0 0 1", data_ready, mem_req, stall_data);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h00001004) begin
            errors++;
            $display("FAIL b2b_second_bus: req=%b addr=%h want 1 00001004", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = r2;
        tick();
        mem_ack = 1'b0;
        c2 = cyc;
        checks++;
        if (data_ready !== 1'b1 || data_rdata !== r2 || (c2 - c1) != 3) begin
            errors++;
            $display("FAIL b2b_second: rdy=%b rdata=%h spacing=%0d want 1 %h 3", data_ready, data_rdata, c2 - c1, r2);
        end
        exp_data_rd = r2;
        data_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit          is_data;
        bit          wr;
        logic [31:0] addr;
        for (int n = 0; n < 24; n++) begin
            is_data = 1'($urandom);
            wr      = 1'($urandom);
            addr    = $urandom;
            do_txn(is_data, wr, addr, $urandom, 4'($urandom), int'($urandom_range(0, TO - 1)),
                   mem_word(addr), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_ack_idle();
        test_collision();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
